// File: rtl/pwm_peripheral_pkg.sv
// pwm_peripheral_pkg: constants and helpers shared by the PWM peripheral.
//   PWM_CNT_W      width of the PWM period counter
//   PWM_DUTY_FULL  duty code meaning "constant high"
//   PWM_NUM_OUT    number of chip outputs driven
package pwm_peripheral_pkg;

    localparam int unsigned          PWM_CNT_W     = 8;
    localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;
    localparam int unsigned          PWM_NUM_OUT   = 16;

    // Full-scale duty is forced high so 0xFF has no one-step low gap at cnt==255.
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == PWM_DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit period counter for the PWM peripheral.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   cnt    out  current PWM step within the period (0..255)
//   tick   out  high in the last prescaler cycle of a step; cnt advances on the next edge
//   wrap   out  tick while cnt==255; the next edge starts a new period
module pwm_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int unsigned PRESCALE = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] cnt,
    output logic                 tick,
    output logic                 wrap
);

    localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PrescW-1:0]    presc_q, presc_d;
    logic [PWM_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick    = (presc_q == PrescW'(PRESCALE - 1));
        wrap    = tick && (cnt_q == '1);
        presc_d = tick ? '0 : presc_q + PrescW'(1);
        // 8-bit add wraps 255->0 on its own
        cnt_d   = tick ? cnt_q + PWM_CNT_W'(1) : cnt_q;
        cnt     = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 chip outputs static low, static high or with a shared PWM
// waveform, from the SPI-written control registers.
// Ports:
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   en_reg_out_7_0   in   output enable, bits 7:0
//   en_reg_out_15_8  in   output enable, bits 15:8
//   en_reg_pwm_7_0   in   PWM-mode select, bits 7:0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8  in   PWM-mode select, bits 15:8
//   pwm_duty_cycle   in   requested duty, applied from the next period boundary
//   pwm_out          out  registered output bus
//   period_start     out  one-clk strobe in the cycle the counter becomes 0
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int unsigned PRESCALE = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             en_reg_out_7_0,
    input  logic [7:0]             en_reg_out_15_8,
    input  logic [7:0]             en_reg_pwm_7_0,
    input  logic [7:0]             en_reg_pwm_15_8,
    input  logic [7:0]             pwm_duty_cycle,
    output logic [PWM_NUM_OUT-1:0] pwm_out,
    output logic                   period_start
);

    logic [PWM_CNT_W-1:0]   cnt;
    logic                   wrap;
    logic                   unused_tick;
    logic [PWM_CNT_W-1:0]   duty_sh_q, duty_sh_d;
    logic [PWM_NUM_OUT-1:0] pwm_out_q, pwm_out_d;
    logic                   period_start_q;
    logic [PWM_NUM_OUT-1:0] en, mode;
    logic                   lvl;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .tick  (unused_tick),
        .wrap  (wrap)
    );

    always_comb begin
        en   = {en_reg_out_15_8, en_reg_out_7_0};
        mode = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        // Shadow only reloads at the period boundary so a pulse is never cut short.
        duty_sh_d = wrap ? pwm_duty_cycle : duty_sh_q;
        lvl       = pwm_level(cnt, duty_sh_q);
        // Disabled -> 0; enabled static -> 1; enabled PWM -> shared level.
        pwm_out_d = en & (~mode | {PWM_NUM_OUT{lvl}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh_q      <= '0;
            pwm_out_q      <= '0;
            period_start_q <= 1'b0;
        end else begin
            duty_sh_q      <= duty_sh_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= wrap;
        end
    end

    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Testbench for pwm_peripheral: one instance at PRESCALE=13 and one at PRESCALE=1 share
// the same register inputs. A time-based reference model predicts every output cycle.
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  en_lo = '0, en_hi = '0, md_lo = '0, md_hi = '0, duty = '0;
    logic [15:0] out13, out1;
    logic        ps13, ps1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_peripheral #(
        .PRESCALE (13)
    ) dut13 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_lo),
        .en_reg_out_15_8 (en_hi),
        .en_reg_pwm_7_0  (md_lo),
        .en_reg_pwm_15_8 (md_hi),
        .pwm_duty_cycle  (duty),
        .pwm_out         (out13),
        .period_start    (ps13)
    );

    pwm_peripheral #(
        .PRESCALE (1)
    ) dut1 (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_lo),
        .en_reg_out_15_8 (en_hi),
        .en_reg_pwm_7_0  (md_lo),
        .en_reg_pwm_15_8 (md_hi),
        .pwm_duty_cycle  (duty),
        .pwm_out         (out1),
        .period_start    (ps1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time since reset release (in clocks) fixes the position inside the period; the duty
    // used by a period is whatever was on the duty input at the clock that ended the
    // previous one (0 for the first period).
    function automatic logic [15:0] exp_bus(input logic [15:0] en, input logic [15:0] mode,
                                            input int unsigned step, input logic [7:0] d);
        logic        hi;
        logic [15:0] r;
        hi = (d == 8'hFF) || (step < int'(d));
        for (int i = 0; i < 16; i++) r[i] = en[i] && (!mode[i] || hi);
        return r;
    endfunction

    int unsigned k13 = 0, k1 = 0;
    logic [7:0]  dsh13 = '0, dsh1 = '0;
    logic [15:0] eo13 = '0, eo1 = '0;
    logic        eps13 = 1'b0, eps1 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k13 = 0; k1 = 0; dsh13 = '0; dsh1 = '0;
            eo13 = '0; eo1 = '0; eps13 = 1'b0; eps1 = 1'b0;
        end else begin
            eo13 = exp_bus({en_hi, en_lo}, {md_hi, md_lo}, (k13 / 13) % 256, dsh13);
            eo1  = exp_bus({en_hi, en_lo}, {md_hi, md_lo}, k1 % 256, dsh1);
            k13++;
            k1++;
            eps13 = (k13 % 3328) == 0;
            eps1  = (k1 % 256) == 0;
            if (eps13) dsh13 = duty;
            if (eps1)  dsh1  = duty;
        end
    end

    // Cycle-by-cycle scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("sb_out13", out13, eo13);
            check_eq("sb_ps13", ps13, eps13);
            check_eq("sb_out1", out1, eo1);
            check_eq("sb_ps1", ps1, eps1);
        end
    end

    // ---------------- helpers ----------------
    task automatic set_regs(input logic [15:0] en, input logic [15:0] mode);
        {en_hi, en_lo} = en;
        {md_hi, md_lo} = mode;
    endtask

    // Clocks until the next period_start of the chosen instance, bounded.
    task automatic wait_ps(input bit sel13, input string tag, output int n);
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 5000) begin
            @(negedge clk);
            n++;
            seen = sel13 ? ps13 : ps1;
        end
        if (!seen) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Counts high samples of bit 0 over n clocks; optional duty writes at two sample indices.
    task automatic count_high(input bit sel13, input int n, input int at_a, input logic [7:0] val_a,
                              input int at_b, input logic [7:0] val_b, output int h);
        h = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            h += int'(sel13 ? out13[0] : out1[0]);
            if (j == at_a) duty = val_a;
            if (j == at_b) duty = val_b;
        end
    endtask

    logic [7:0] bnd_duty [3] = '{8'h00, 8'hFF, 8'h01};
    int         bnd_high [3] = '{0, 256, 1};

    initial begin
        int n, h;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out13", out13, 16'h0000);
        check_eq("rst_ps13", ps13, 1'b0);
        check_eq("rst_out1", out1, 16'h0000);
        #2 rst_n = 1'b1;

        // Static modes
        @(negedge clk);
        set_regs(16'hFFFF, 16'h0000);
        @(negedge clk);
        check_eq("static_all13", out13, 16'hFFFF);
        check_eq("static_all1", out1, 16'hFFFF);
        set_regs(16'h00F0, 16'h0000);
        @(negedge clk);
        check_eq("static_f0_13", out13, 16'h00F0);
        check_eq("static_f0_1", out1, 16'h00F0);

        // Asynchronous reset mid-period, then first strobe a full period after release
        set_regs(16'hFFFF, 16'h0000);
        repeat (1000) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_rst_out13", out13, 16'h0000);
        check_eq("async_rst_ps13", ps13, 1'b0);
        check_eq("async_rst_out1", out1, 16'h0000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ps(1'b1, "first_period", n);
        check_eq("first_period13", n, 3328);

        // Period length at both prescales
        for (int i = 0; i < 2; i++) begin
            wait_ps(1'b1, "period13", n);
            check_eq("period13", n, 3328);
        end
        for (int i = 0; i < 3; i++) begin
            wait_ps(1'b0, "period1", n);
            check_eq("period1", n, 256);
        end

        // Half duty at PRESCALE=1
        set_regs(16'h0001, 16'h0001);
        duty = 8'h80;
        wait_ps(1'b0, "duty80", n);
        count_high(1'b0, 256, 0, 8'h00, 0, 8'h00, h);
        check_eq("duty80_high", h, 128);

        // Boundary duties at PRESCALE=1
        for (int i = 0; i < 3; i++) begin
            duty = bnd_duty[i];
            wait_ps(1'b0, "bnd", n);
            count_high(1'b0, 256, 0, 8'h00, 0, 8'h00, h);
            check_eq($sformatf("bnd_duty_%02h", bnd_duty[i]), h, bnd_high[i]);
        end

        // Mid-period duty change at cnt=100, then a write present only on the wrap edge
        duty = 8'h40;
        wait_ps(1'b1, "mid", n);
        count_high(1'b1, 3328, 1300, 8'hC0, 0, 8'h00, h);
        check_eq("mid_cur_period", h, 64 * 13);
        count_high(1'b1, 3328, 3327, 8'h10, 3328, 8'hC0, h);
        check_eq("mid_next_period", h, 192 * 13);
        count_high(1'b1, 3328, 0, 8'h00, 0, 8'h00, h);
        check_eq("wrap_clk_write", h, 16 * 13);

        // Randomised register traffic, one asynchronous reset pulse in the middle
        for (int it = 0; it < 200; it++) begin
            int r;
            repeat ($urandom_range(1, 40)) @(negedge clk);
            en_lo = 8'($urandom);
            en_hi = 8'($urandom);
            md_lo = 8'($urandom);
            md_hi = 8'($urandom);
            r = $urandom_range(0, 3);
            duty = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
            if (it == 100) begin
                #3 rst_n = 1'b0;
                #1;
                check_eq("rand_rst_out13", out13, 16'h0000);
                check_eq("rand_rst_out1", out1, 16'h0000);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        repeat (300) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
